// File: rtl/emu_scan_pkg.sv
// Shared definitions for the emulation checkpoint scan controller.
// Optional feature macro used by the controller: EMU_SCAN_CHECKSUM_EN.
package emu_scan_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      PAUSING   = 3'd1,
      PAUSED    = 3'd2,
      FF_SCAN   = 3'd3,
      RAM_SCAN  = 3'd4,
      RAM_DRAIN = 3'd5,
      DONE      = 3'd6
   } scan_state_e;

   localparam logic SCAN_SAVE = 1'b0;
   localparam logic SCAN_LOAD = 1'b1;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/emu_scan_skid.sv
// Two-entry skid buffer for RAM-chain read data. has_room accounts for a read
// already issued whose data lands next cycle, so the buffer can never overflow.
module emu_scan_skid #(
   parameter int DW = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   input  logic          reserve,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   output logic          has_room
);

   logic [DW-1:0] mem_q [2];
   logic          wr_ptr_q;
   logic          rd_ptr_q;
   logic [1:0]    count_q;
   logic          do_pop;
   logic [2:0]    occupancy;

   assign do_pop    = pop && (count_q != 2'd0);
   assign out_valid = (count_q != 2'd0);
   assign out_data  = mem_q[rd_ptr_q];

   // A pop this cycle frees a slot in time for a read issued this cycle.
   assign occupancy = {1'b0, count_q} + {2'b00, reserve} - {2'b00, do_pop};
   assign has_room  = (occupancy < 3'd2);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) mem_q[i] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= push_data;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (do_pop) rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_q + {1'b0, push} - {1'b0, do_pop};
      end
   end

endmodule

// File: rtl/emu_scan_ctrl.sv
// Checkpoint scan controller: freezes the emulated DUT and streams its FF then RAM
// chains out (save) or in (load). EMU_SCAN_CHECKSUM_EN adds a rotate-xor checksum port.
module emu_scan_ctrl
   import emu_scan_pkg::*;
#(
   parameter int DW        = 64,
   parameter int FF_WORDS  = 4,
   parameter int RAM_WORDS = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pause_req,
   output logic          pause,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_load,
   output logic          dout_valid,
   input  logic          dout_ready,
   output logic [DW-1:0] dout_data,
   input  logic          din_valid,
   output logic          din_ready,
   input  logic [DW-1:0] din_data,
   output logic          done,
   output logic          ff_se,
   output logic          ff_sd,
   output logic [DW-1:0] ff_di,
   input  logic [DW-1:0] ff_do,
   output logic          ram_se,
   output logic          ram_sd,
   output logic [DW-1:0] ram_di,
   input  logic [DW-1:0] ram_do,
   output logic [2:0]    dbg_state
`ifdef EMU_SCAN_CHECKSUM_EN
   ,
   output logic [DW-1:0] checksum
`endif
);

   localparam int CW = $clog2(max_int(FF_WORDS, RAM_WORDS)) + 1;
   localparam logic [CW-1:0] FF_LAST  = CW'(FF_WORDS - 1);
   localparam logic [CW-1:0] RAM_LAST = CW'(RAM_WORDS - 1);

   scan_state_e   state_q, state_d;
   logic [CW-1:0] cnt_q;
   logic          mode_q;
   logic          pause_q;
   logic          rd_pend_q;
   logic          step;
   logic          accept;
   logic          skid_pop;
   logic          skid_valid;
   logic [DW-1:0] skid_data;
   logic          skid_room;

   // Streams use strict valid/ready: a word moves in a cycle where both are high;
   // the producer holds valid and data stable until that cycle.
   assign accept    = (state_q == PAUSED) && cmd_valid;
   assign cmd_ready = (state_q == PAUSED);
   assign done      = (state_q == DONE);
   assign pause     = pause_q;
   assign dbg_state = state_q;

   emu_scan_skid #(.DW(DW)) u_skid (
      .clk       (clk),
      .rst       (rst),
      .push      (rd_pend_q),
      .push_data (ram_do),
      .pop       (skid_pop),
      .reserve   (rd_pend_q),
      .out_valid (skid_valid),
      .out_data  (skid_data),
      .has_room  (skid_room)
   );

   always_comb begin
      state_d    = state_q;
      step       = 1'b0;
      skid_pop   = 1'b0;
      ff_se      = 1'b0;
      ff_sd      = 1'b0;
      ff_di      = '0;
      ram_se     = 1'b0;
      ram_sd     = 1'b0;
      ram_di     = '0;
      dout_valid = 1'b0;
      dout_data  = '0;
      din_ready  = 1'b0;
      case (state_q)
         IDLE: if (pause_req) state_d = PAUSING;
         PAUSING: state_d = PAUSED;
         PAUSED: begin
            if (accept)          state_d = FF_SCAN;
            else if (!pause_req) state_d = IDLE;
         end
         FF_SCAN: begin
            if (mode_q == SCAN_LOAD) begin
               din_ready = 1'b1;
               step      = din_valid;
               ff_sd     = din_valid;
               ff_di     = din_data;
            end else begin
               // Chain loops back on itself, so a full pass leaves FF state intact.
               dout_valid = 1'b1;
               dout_data  = ff_do;
               step       = dout_ready;
            end
            ff_se = step;
            if (step && (cnt_q == FF_LAST)) state_d = RAM_SCAN;
         end
         RAM_SCAN: begin
            if (mode_q == SCAN_LOAD) begin
               din_ready = 1'b1;
               step      = din_valid;
               ram_sd    = din_valid;
               ram_di    = din_data;
               if (step && (cnt_q == RAM_LAST)) state_d = DONE;
            end else begin
               dout_valid = skid_valid;
               dout_data  = skid_data;
               skid_pop   = skid_valid && dout_ready;
               step       = skid_room;
               if (step && (cnt_q == RAM_LAST)) state_d = RAM_DRAIN;
            end
            ram_se = step;
         end
         RAM_DRAIN: begin
            dout_valid = skid_valid;
            dout_data  = skid_data;
            skid_pop   = skid_valid && dout_ready;
            if (!skid_valid && !rd_pend_q) state_d = DONE;
         end
         DONE: state_d = PAUSED;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         mode_q    <= SCAN_SAVE;
         pause_q   <= 1'b0;
         rd_pend_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pause_q   <= (state_d != IDLE);
         rd_pend_q <= ram_se && !ram_sd;
         if (state_d != state_q) cnt_q <= '0;
         else if (step)          cnt_q <= cnt_q + CW'(1);
         if (accept) mode_q <= cmd_load;
      end
   end

`ifdef EMU_SCAN_CHECKSUM_EN
   logic          xfer;
   logic [DW-1:0] xfer_data;
   logic [DW-1:0] csum_q;

   always_comb begin
      xfer      = 1'b0;
      xfer_data = '0;
      if ((state_q == FF_SCAN) || ((state_q == RAM_SCAN) && (mode_q == SCAN_LOAD))) begin
         xfer      = step;
         xfer_data = (mode_q == SCAN_LOAD) ? din_data : ff_do;
      end else if ((state_q == RAM_SCAN) || (state_q == RAM_DRAIN)) begin
         xfer      = skid_pop;
         xfer_data = skid_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || accept) csum_q <= '0;
      else if (xfer)     csum_q <= {csum_q[DW-2:0], csum_q[DW-1]} ^ xfer_data;
   end

   assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_emu_scan_ctrl.sv
// Self-checking bench for emu_scan_ctrl driving a small behavioural scan-chain target.
module tb_emu_scan_ctrl;
   import emu_scan_pkg::*;

   localparam int DW   = 64;
   localparam int FFW  = 2;
   localparam int RAMW = 4;
   localparam int NW   = FFW + RAMW;

   logic          clk = 1'b0;
   logic          rst, pause_req, pause, cmd_valid, cmd_ready, cmd_load;
   logic          dout_valid, dout_ready, din_valid, din_ready, done;
   logic [DW-1:0] dout_data, din_data;
   logic          ff_se, ff_sd, ram_se, ram_sd;
   logic [DW-1:0] ff_di, ff_do, ram_di, ram_do;
   logic [2:0]    dbg_state;
`ifdef EMU_SCAN_CHECKSUM_EN
   logic [DW-1:0] checksum;
`endif

   always #5 clk = ~clk;

   emu_scan_ctrl #(.DW(DW), .FF_WORDS(FFW), .RAM_WORDS(RAMW)) dut (
      .clk(clk), .rst(rst), .pause_req(pause_req), .pause(pause),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
      .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
      .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
      .done(done), .ff_se(ff_se), .ff_sd(ff_sd), .ff_di(ff_di), .ff_do(ff_do),
      .ram_se(ram_se), .ram_sd(ram_sd), .ram_di(ram_di), .ram_do(ram_do),
      .dbg_state(dbg_state)
`ifdef EMU_SCAN_CHECKSUM_EN
      , .checksum(checksum)
`endif
   );

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_bit(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Scan target: FF chain shifts from head toward tail, RAM chain is an address-stepped array.
   logic [DW-1:0] ff_chain [FFW];
   logic [DW-1:0] ram_mem  [RAMW];
   logic [DW-1:0] seed_ff  [FFW];
   logic [DW-1:0] seed_ram [RAMW];
   logic [DW-1:0] ram_do_r;
   int            ram_ptr;

   assign ff_do  = ff_chain[0];
   assign ram_do = ram_do_r;

   always @(posedge clk) begin
      if (rst) begin
         ff_chain <= seed_ff;
         ram_mem  <= seed_ram;
         ram_ptr  <= 0;
         ram_do_r <= '0;
      end else begin
         if (ff_se) begin
            for (int i = 0; i < FFW - 1; i++) ff_chain[i] <= ff_chain[i+1];
            ff_chain[FFW-1] <= ff_sd ? ff_di : ff_chain[0];
         end
         if (ram_se) begin
            if (ram_sd) ram_mem[ram_ptr] <= ram_di;
            else        ram_do_r <= ram_mem[ram_ptr];
            ram_ptr <= (ram_ptr + 1) % RAMW;
         end
      end
   end

   logic [DW-1:0] got_q [$];
   int            done_cnt = 0;

   always @(posedge clk) begin
      if (!rst && dout_valid && dout_ready) got_q.push_back(dout_data);
      if (done) done_cnt++;
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (ff_se || ram_se) chk_bit("se_exclusive", ff_se && ram_se, 1'b0);
         if (ff_se && !ff_sd) chk_bit("ff_save_needs_accept", dout_valid && dout_ready, 1'b1);
         if ((ff_se && ff_sd) || (ram_se && ram_sd))
            chk_bit("load_step_needs_handshake", din_valid && din_ready, 1'b1);
         if (ff_se && ff_sd) chk("ff_di_follows_din", ff_di, din_data);
      end
   end

   logic [DW-1:0] exp_ff  [FFW];
   logic [DW-1:0] exp_ram [RAMW];
   logic [DW-1:0] load_words [NW];

   function automatic logic [DW-1:0] ref_csum(input logic [DW-1:0] w [$]);
      logic [DW-1:0] cs = '0;
      foreach (w[i]) cs = ((cs << 1) | (cs >> (DW - 1))) ^ w[i];
      return cs;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_target(input string tag);
      for (int i = 0; i < FFW; i++)  chk({tag, "_ff_state"}, ff_chain[i], exp_ff[i]);
      for (int i = 0; i < RAMW; i++) chk({tag, "_ram_state"}, ram_mem[i], exp_ram[i]);
   endtask

   task automatic go_paused(input string tag);
      bit ok = 0;
      pause_req = 1'b1;
      for (int c = 0; c < 10 && !ok; c++) begin
         tick();
         if (cmd_ready) ok = 1;
      end
      chk_bit({tag, "_paused"}, ok, 1'b1);
   endtask

   task automatic run_save(input int pct, input bit drop_req, input string tag);
      logic [DW-1:0] exp_q [$];
      int  d0 = done_cnt;
      bit  ok = 0;
      for (int i = 0; i < FFW; i++)  exp_q.push_back(exp_ff[i]);
      for (int i = 0; i < RAMW; i++) exp_q.push_back(exp_ram[i]);
      got_q.delete();
      chk_bit({tag, "_cmd_ready"}, cmd_ready, 1'b1);
      cmd_load  = 1'b0;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      if (drop_req) pause_req = 1'b0;
      for (int c = 0; c < 400 && !ok; c++) begin
         dout_ready = ($urandom_range(0, 99) < pct);
         tick();
         if (drop_req) chk_bit({tag, "_pause_held"}, pause, 1'b1);
         if (done) ok = 1;
      end
      dout_ready = 1'b0;
      chk_bit({tag, "_done_seen"}, ok, 1'b1);
      chk({tag, "_word_count"}, DW'(got_q.size()), DW'(NW));
      for (int i = 0; i < NW && i < got_q.size(); i++) chk({tag, "_word"}, got_q[i], exp_q[i]);
`ifdef EMU_SCAN_CHECKSUM_EN
      chk({tag, "_checksum"}, checksum, ref_csum(exp_q));
`endif
      tick();
      chk_bit({tag, "_done_one_cycle"}, done, 1'b0);
      chk({tag, "_done_pulses"}, DW'(done_cnt - d0), DW'(1));
      chk_bit({tag, "_back_paused"}, cmd_ready, 1'b1);
      check_target(tag);
      if (drop_req) begin
         chk_bit({tag, "_pause_in_paused"}, pause, 1'b1);
         tick();
         chk_bit({tag, "_pause_released"}, pause, 1'b0);
         chk_bit({tag, "_idle_not_ready"}, cmd_ready, 1'b0);
      end
   endtask

   task automatic run_load(input int pct, input string tag);
      logic [DW-1:0] sent_q [$];
      int idx = 0;
      bit ok  = 0;
      bit hs;
      chk_bit({tag, "_cmd_ready"}, cmd_ready, 1'b1);
      cmd_load  = 1'b1;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      for (int c = 0; c < 400 && !ok; c++) begin
         din_valid = (idx < NW) && ($urandom_range(0, 99) < pct);
         din_data  = din_valid ? load_words[idx] : {$urandom, $urandom};
         @(negedge clk);
         hs = din_valid && din_ready;
         tick();
         if (hs) begin
            sent_q.push_back(load_words[idx]);
            idx++;
         end
         if (done) ok = 1;
      end
      din_valid = 1'b0;
      chk_bit({tag, "_done_seen"}, ok, 1'b1);
      chk({tag, "_words_taken"}, DW'(idx), DW'(NW));
`ifdef EMU_SCAN_CHECKSUM_EN
      chk({tag, "_checksum"}, checksum, ref_csum(sent_q));
`endif
      for (int i = 0; i < FFW; i++)  exp_ff[i]  = load_words[i];
      for (int i = 0; i < RAMW; i++) exp_ram[i] = load_words[FFW + i];
      tick();
      check_target(tag);
   endtask

   initial begin
      bit seen;
      int d0;
      rst = 1'b1; pause_req = 1'b0; cmd_valid = 1'b0; cmd_load = 1'b0;
      dout_ready = 1'b0; din_valid = 1'b0; din_data = '0;
      for (int i = 0; i < FFW; i++)  seed_ff[i]  = {$urandom, $urandom};
      for (int i = 0; i < RAMW; i++) seed_ram[i] = {$urandom, $urandom};
      exp_ff  = seed_ff;
      exp_ram = seed_ram;
      repeat (3) tick();
      rst = 1'b0;

      chk_bit("rst_pause", pause, 1'b0);
      chk_bit("rst_cmd_ready", cmd_ready, 1'b0);
      chk_bit("rst_dout_valid", dout_valid, 1'b0);
      chk_bit("rst_din_ready", din_ready, 1'b0);
      chk_bit("rst_done", done, 1'b0);
      chk_bit("rst_ff_se", ff_se, 1'b0);
      chk_bit("rst_ram_se", ram_se, 1'b0);
      chk("rst_dout_data", dout_data, '0);

      // Commands while running are ignored.
      cmd_valid = 1'b1;
      repeat (3) begin
         tick();
         chk_bit("idle_cmd_ignored_ready", cmd_ready, 1'b0);
         chk_bit("idle_cmd_ignored_se", ff_se || ram_se, 1'b0);
         chk_bit("idle_cmd_ignored_pause", pause, 1'b0);
      end
      cmd_valid = 1'b0;

      pause_req = 1'b1;
      tick();
      chk_bit("pause_after_1", pause, 1'b1);
      chk_bit("not_ready_after_1", cmd_ready, 1'b0);
      tick();
      chk_bit("ready_after_2", cmd_ready, 1'b1);
      chk("dbg_state_paused", DW'(dbg_state), DW'(PAUSED));
      check_target("pause_no_disturb");

      run_save(100, 1'b0, "save_full");
      run_save(50, 1'b1, "save_rand");
      go_paused("repause");

      for (int i = 0; i < NW; i++) load_words[i] = {$urandom, $urandom};
      load_words[FFW + 2] = 64'h0000_0000_DEAD_BEEF;
      run_load(70, "load");
      chk("load_ram2", ram_mem[2], 64'h0000_0000_DEAD_BEEF);
      run_save(60, 1'b0, "save_after_load");

      // Abort mid RAM phase, target reloads 1..6 on reset.
      for (int i = 0; i < FFW; i++)  seed_ff[i]  = DW'(i + 1);
      for (int i = 0; i < RAMW; i++) seed_ram[i] = DW'(FFW + i + 1);
      d0 = done_cnt;
      cmd_load  = 1'b0;
      cmd_valid = 1'b1;
      tick();
      cmd_valid  = 1'b0;
      dout_ready = 1'b1;
      seen = 0;
      for (int c = 0; c < 50 && !seen; c++) begin
         tick();
         if (ram_se) seen = 1;
      end
      chk_bit("abort_reached_ram", seen, 1'b1);
      rst = 1'b1;
      tick();
      chk_bit("abort_pause", pause, 1'b0);
      chk_bit("abort_se", ff_se || ram_se, 1'b0);
      chk_bit("abort_done", done, 1'b0);
      chk_bit("abort_dout_valid", dout_valid, 1'b0);
      rst = 1'b0;
      dout_ready = 1'b0;
      chk("abort_no_done_pulse", DW'(done_cnt - d0), DW'(0));
      exp_ff  = seed_ff;
      exp_ram = seed_ram;
      go_paused("abort_repause");
      run_save(100, 1'b0, "fresh_save");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout observed=running expected=finished");
      $fatal(1, "watchdog");
   end

endmodule
